// File: rtl/ctrl_pkg.sv
// Shared types for the anomaly response controller: FSM states and ALU flag layout.
package ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STALL    = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_COOLDOWN = 2'd3
  } ctrl_state_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/resp_cycle_timer.sv
// Loadable down-counter with a zero flag; times both the stall and cooldown intervals.
module resp_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  // A load always wins over a decrement; the count parks at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/anomaly_response_ctrl.sv
// Anomaly response controller: stall -> flush handshake -> cooldown, with recurrence escalation.
// Optional flag snapshot output is enabled by defining ANOMALY_SNAPSHOT_EN.
module anomaly_response_ctrl
  import ctrl_pkg::*;
#(
  parameter int STALL_CYCLES    = 2,
  parameter int COOLDOWN_CYCLES = 8,
  parameter int ESCALATE_THRESH = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             anomaly_in,
  input  flags_t           flags_in,
  input  logic             flush_ack_in,
  input  logic             clear_escalate_in,
  output logic             stall_out,
  output logic             flush_req_out,
  output logic             escalate_out,
  output logic             busy_out,
  output logic [CNT_W-1:0] anomaly_count_out
`ifdef ANOMALY_SNAPSHOT_EN
  ,
  output flags_t           snapshot_out
`endif
);

  localparam int TMAX = (STALL_CYCLES > COOLDOWN_CYCLES) ? STALL_CYCLES : COOLDOWN_CYCLES;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int QW   = $clog2(COOLDOWN_CYCLES + 1);
  localparam int RW   = $clog2(ESCALATE_THRESH + 1);

  ctrl_state_t   state;
  logic          pending;
  logic          tmr_zero;
  logic          tmr_load;
  logic          tmr_dec;
  logic [TW-1:0] tmr_val;
  logic          ack_seen;
  logic          cool_done;
  logic          pend_eff;
  logic          accept;
  logic [QW-1:0] quiet_cnt;
  logic [RW-1:0] recur_cnt;

  // An anomaly arriving on the cooldown expiry cycle counts as pending so it is not lost.
  assign ack_seen  = (state == ST_FLUSH) && flush_req_out && flush_ack_in;
  assign cool_done = (state == ST_COOLDOWN) && tmr_zero;
  assign pend_eff  = pending | anomaly_in;
  assign accept    = ((state == ST_IDLE) && anomaly_in) || (cool_done && pend_eff);
  assign tmr_load  = accept || ack_seen;
  assign tmr_val   = ack_seen ? TW'(COOLDOWN_CYCLES - 1) : TW'(STALL_CYCLES - 1);
  assign tmr_dec   = (state == ST_STALL) || (state == ST_COOLDOWN);

  resp_cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      stall_out     <= 1'b0;
      flush_req_out <= 1'b0;
      busy_out      <= 1'b0;
      pending       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (anomaly_in) begin
            state     <= ST_STALL;
            stall_out <= 1'b1;
            busy_out  <= 1'b1;
          end
        end
        ST_STALL: begin
          pending <= pend_eff;
          if (tmr_zero) begin
            state         <= ST_FLUSH;
            flush_req_out <= 1'b1;
          end
        end
        ST_FLUSH: begin
          pending <= pend_eff;
          if (ack_seen) begin
            state         <= ST_COOLDOWN;
            stall_out     <= 1'b0;
            flush_req_out <= 1'b0;
          end
        end
        ST_COOLDOWN: begin
          if (tmr_zero) begin
            pending <= 1'b0;
            if (pend_eff) begin
              state     <= ST_STALL;
              stall_out <= 1'b1;
            end else begin
              state    <= ST_IDLE;
              busy_out <= 1'b0;
            end
          end else begin
            pending <= pend_eff;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      anomaly_count_out <= '0;
      recur_cnt         <= '0;
      quiet_cnt         <= '0;
      escalate_out      <= 1'b0;
    end else begin
      if (accept && (anomaly_count_out != {CNT_W{1'b1}})) begin
        anomaly_count_out <= anomaly_count_out + CNT_W'(1);
      end
      // Quiet IDLE cycles age out the recurrence history.
      if ((state == ST_IDLE) && !anomaly_in) begin
        if (quiet_cnt != QW'(COOLDOWN_CYCLES)) begin
          quiet_cnt <= quiet_cnt + QW'(1);
        end
        if (quiet_cnt == QW'(COOLDOWN_CYCLES - 1)) begin
          recur_cnt <= '0;
        end
      end else begin
        quiet_cnt <= '0;
        if (accept && (recur_cnt != RW'(ESCALATE_THRESH))) begin
          recur_cnt <= recur_cnt + RW'(1);
        end
      end
      if (accept && (recur_cnt == RW'(ESCALATE_THRESH - 1))) begin
        escalate_out <= 1'b1;
      end else if (clear_escalate_in) begin
        escalate_out <= 1'b0;
      end
    end
  end

`ifdef ANOMALY_SNAPSHOT_EN
  flags_t pend_flags;

  // A deferred response reports the flags seen when its pending bit was first set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_flags   <= '0;
      snapshot_out <= '0;
    end else begin
      if ((state != ST_IDLE) && anomaly_in && !pending) begin
        pend_flags <= flags_in;
      end
      if (accept) begin
        snapshot_out <= (cool_done && pending) ? pend_flags : flags_in;
      end
    end
  end
`else
  logic unused_flags;
  assign unused_flags = ^flags_in;
`endif

endmodule

// File: tb/tb_anomaly_response_ctrl.sv
// Bench for anomaly_response_ctrl; also checks snapshot_out when ANOMALY_SNAPSHOT_EN is defined.
module tb_anomaly_response_ctrl;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       anomaly_in = 1'b0;
  flags_t     flags_in = '0;
  logic       flush_ack_in = 1'b0;
  logic       clear_escalate_in = 1'b0;
  logic       stall_out, flush_req_out, escalate_out, busy_out;
  logic [7:0] anomaly_count_out;
  logic       sat_stall, sat_flush, sat_esc, sat_busy;
  logic [1:0] sat_count;
`ifdef ANOMALY_SNAPSHOT_EN
  flags_t     snapshot_out, sat_snapshot;
`endif

  int n_pass = 0;
  int n_total = 0;
  int exp_count = 0;
  logic [13:0] exp_q[$];
  logic stall_prev = 1'b0;

  always #5 clk = ~clk;

  anomaly_response_ctrl u_dut (
    .clk(clk), .reset(reset), .anomaly_in(anomaly_in), .flags_in(flags_in),
    .flush_ack_in(flush_ack_in), .clear_escalate_in(clear_escalate_in),
    .stall_out(stall_out), .flush_req_out(flush_req_out), .escalate_out(escalate_out),
    .busy_out(busy_out), .anomaly_count_out(anomaly_count_out)
`ifdef ANOMALY_SNAPSHOT_EN
    , .snapshot_out(snapshot_out)
`endif
  );

  anomaly_response_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .anomaly_in(anomaly_in), .flags_in(flags_in),
    .flush_ack_in(flush_ack_in), .clear_escalate_in(clear_escalate_in),
    .stall_out(sat_stall), .flush_req_out(sat_flush), .escalate_out(sat_esc),
    .busy_out(sat_busy), .anomaly_count_out(sat_count)
`ifdef ANOMALY_SNAPSHOT_EN
    , .snapshot_out(sat_snapshot)
`endif
  );

  // Scoreboard: every rising stall_out is an accepted response and consumes one expectation.
  always @(negedge clk) begin
    logic [13:0] e;
    logic ok;
    if (!stall_prev && stall_out) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_accept: count=%0d, no response expected", anomaly_count_out);
      end else begin
        e = exp_q.pop_front();
`ifdef ANOMALY_SNAPSHOT_EN
        ok = (anomaly_count_out === e[13:6]) && (sat_count === e[5:4]) && (snapshot_out === e[3:0]);
        if (!ok) $display("FAIL accept: count=%0d sat=%0d snap=%b, want %0d %0d %b",
                          anomaly_count_out, sat_count, snapshot_out, e[13:6], e[5:4], e[3:0]);
`else
        ok = (anomaly_count_out === e[13:6]) && (sat_count === e[5:4]);
        if (!ok) $display("FAIL accept: count=%0d sat=%0d, want %0d %0d",
                          anomaly_count_out, sat_count, e[13:6], e[5:4]);
`endif
        if (ok) n_pass++;
      end
    end
    stall_prev = stall_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input flags_t f);
    logic [7:0] c8;
    logic [1:0] c2;
    if (exp_count != 255) exp_count++;
    c8 = exp_count[7:0];
    c2 = (exp_count > 3) ? 2'd3 : exp_count[1:0];
    exp_q.push_back({c8, c2, f});
  endtask

  task automatic apply_reset();
    anomaly_in = 1'b0;
    clear_escalate_in = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
    exp_count = 0;
    tick();
  endtask

  task automatic start_accept(input flags_t f);
    flags_in = f;
    anomaly_in = 1'b1;
    push_exp(f);
    tick();
    anomaly_in = 1'b0;
  endtask

  task automatic finish_response();
    int n;
    n = 0;
    while (!flush_req_out && n < 20) begin tick(); n++; end
    if (!flush_req_out) begin
      n_total++;
      $display("FAIL timeout_flush: flush_req_out=%b after %0d cycles, want 1", flush_req_out, n);
    end
    repeat ($urandom_range(0, 3)) tick();
    flush_ack_in = 1'b1;
    tick();
    flush_ack_in = 1'b0;
    n = 0;
    while (busy_out && n < 30) begin tick(); n++; end
    if (busy_out) begin
      n_total++;
      $display("FAIL timeout_idle: busy_out=%b after %0d cycles, want 0", busy_out, n);
    end
  endtask

  task automatic do_response();
    start_accept(flags_t'($urandom_range(0, 15)));
    finish_response();
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++;
    if ({stall_out, flush_req_out, escalate_out, busy_out, anomaly_count_out, sat_count} !== 14'd0)
      $display("FAIL reset_outputs: got %b, want all 0",
               {stall_out, flush_req_out, escalate_out, busy_out, anomaly_count_out, sat_count});
    else n_pass++;
`ifdef ANOMALY_SNAPSHOT_EN
    n_total++;
    if (snapshot_out !== 4'd0) $display("FAIL reset_snapshot: got %b, want 0000", snapshot_out);
    else n_pass++;
`endif
  endtask

  task automatic test_basic();
    int n;
    apply_reset();
    start_accept(4'b0011);
    n_total++;
    if ({stall_out, flush_req_out, busy_out} !== 3'b101)
      $display("FAIL basic_stall_rise: s/f/b=%b, want 101", {stall_out, flush_req_out, busy_out});
    else n_pass++;
    tick();
    n_total++;
    if (flush_req_out !== 1'b0) $display("FAIL basic_flush_early: got %b, want 0", flush_req_out);
    else n_pass++;
    tick();
    n_total++;
    if (flush_req_out !== 1'b1) $display("FAIL basic_flush_rise: got %b, want 1", flush_req_out);
    else n_pass++;
    tick();
    tick();
    flush_ack_in = 1'b1;
    tick();
    flush_ack_in = 1'b0;
    n_total++;
    if ({stall_out, flush_req_out, busy_out} !== 3'b001)
      $display("FAIL basic_ack_edge: s/f/b=%b, want 001", {stall_out, flush_req_out, busy_out});
    else n_pass++;
    n = 0;
    while (busy_out && n < 20) begin tick(); n++; end
    n_total++;
    if (n !== 8) $display("FAIL basic_cooldown_len: got %0d cycles, want 8", n);
    else n_pass++;
    n_total++;
    if (anomaly_count_out !== 8'd1) $display("FAIL basic_count: got %0d, want 1", anomaly_count_out);
    else n_pass++;
  endtask

  task automatic test_ack_held();
    int n;
    flush_ack_in = 1'b1;
    apply_reset();
    tick();
    tick();
    n_total++;
    if ({flush_req_out, busy_out} !== 2'b00)
      $display("FAIL ackheld_idle: f/b=%b, want 00", {flush_req_out, busy_out});
    else n_pass++;
    start_accept(4'b0100);
    tick();
    n_total++;
    if ({stall_out, flush_req_out} !== 2'b10)
      $display("FAIL ackheld_stall: s/f=%b, want 10", {stall_out, flush_req_out});
    else n_pass++;
    tick();
    n_total++;
    if (flush_req_out !== 1'b1) $display("FAIL ackheld_flush: got %b, want 1", flush_req_out);
    else n_pass++;
    tick();
    n_total++;
    if ({stall_out, flush_req_out, busy_out} !== 3'b001)
      $display("FAIL ackheld_cooldown: s/f/b=%b, want 001", {stall_out, flush_req_out, busy_out});
    else n_pass++;
    flush_ack_in = 1'b0;
    n = 0;
    while (busy_out && n < 20) begin tick(); n++; end
    n_total++;
    if (busy_out !== 1'b0) $display("FAIL ackheld_idle_return: busy=%b, want 0", busy_out);
    else n_pass++;
  endtask

  task automatic test_pending();
    int n;
    logic busy_drop;
    apply_reset();
    start_accept(4'b0001);
    flags_in = 4'b0110;
    anomaly_in = 1'b1;
    push_exp(4'b0110);
    tick();
    anomaly_in = 1'b0;
    flags_in = 4'b0000;
    tick();
    flush_ack_in = 1'b1;
    tick();
    flush_ack_in = 1'b0;
    flags_in = 4'b1001;
    anomaly_in = 1'b1;
    tick();
    anomaly_in = 1'b0;
    flags_in = 4'b1111;
    n = 0;
    busy_drop = 1'b0;
    while (!stall_out && n < 20) begin
      tick();
      n++;
      if (!busy_out) busy_drop = 1'b1;
    end
    n_total++;
    if (n !== 7 || busy_drop !== 1'b0)
      $display("FAIL pending_direct: restall after %0d cycles busy_drop=%b, want 7 and 0", n, busy_drop);
    else n_pass++;
    finish_response();
    n_total++;
    if (anomaly_count_out !== 8'd2) $display("FAIL pending_count: got %0d, want 2", anomaly_count_out);
    else n_pass++;
  endtask

  task automatic test_escalate();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      do_response();
      repeat (7) tick();
    end
    n_total++;
    if (escalate_out !== 1'b0) $display("FAIL esc_early: got %b, want 0", escalate_out);
    else n_pass++;
    start_accept(4'b1000);
    n_total++;
    if (escalate_out !== 1'b1) $display("FAIL esc_set: got %b, want 1", escalate_out);
    else n_pass++;
    finish_response();
    n_total++;
    if (escalate_out !== 1'b1) $display("FAIL esc_sticky: got %b, want 1", escalate_out);
    else n_pass++;
    clear_escalate_in = 1'b1;
    tick();
    clear_escalate_in = 1'b0;
    n_total++;
    if (escalate_out !== 1'b0) $display("FAIL esc_clear: got %b, want 0", escalate_out);
    else n_pass++;
    repeat (8) tick();
    for (int i = 0; i < 4; i++) begin
      do_response();
      repeat (8) tick();
      n_total++;
      if (escalate_out !== 1'b0) $display("FAIL esc_quiet_%0d: got %b, want 0", i, escalate_out);
      else n_pass++;
    end
  endtask

  task automatic test_reset_in_flush();
    apply_reset();
    start_accept(4'b0010);
    tick();
    tick();
    n_total++;
    if (flush_req_out !== 1'b1) $display("FAIL rst_reach_flush: got %b, want 1", flush_req_out);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++;
    if ({stall_out, flush_req_out, escalate_out, busy_out, anomaly_count_out} !== 12'd0)
      $display("FAIL rst_async: got %b, want all 0",
               {stall_out, flush_req_out, escalate_out, busy_out, anomaly_count_out});
    else n_pass++;
    exp_q.delete();
    exp_count = 0;
    tick();
    reset = 1'b0;
    tick();
    do_response();
    n_total++;
    if (anomaly_count_out !== 8'd1) $display("FAIL rst_restart_count: got %0d, want 1", anomaly_count_out);
    else n_pass++;
  endtask

  task automatic test_saturation();
    flags_t f;
    apply_reset();
    f = '0;
    f[FLAG_Z] = 1'b1;
    f[FLAG_C] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start_accept(f);
      finish_response();
    end
    n_total++;
    if (anomaly_count_out !== 8'd5 || sat_count !== 2'd3)
      $display("FAIL sat_counts: got %0d/%0d, want 5/3", anomaly_count_out, sat_count);
    else n_pass++;
`ifdef ANOMALY_SNAPSHOT_EN
    n_total++;
    if (snapshot_out !== 4'b1010) $display("FAIL sat_snapshot: got %b, want 1010", snapshot_out);
    else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ack_held();
    test_pending();
    test_escalate();
    test_reset_in_flush();
    test_saturation();
    tick();
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL leftover_expected: %0d queued, want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
